// File: rtl/mod_mult_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mod_pkg
// Shared definitions for the modulation-multiplier scheduler slice.
//   MOD_W   default operand width (product is 2*MOD_W)
//   MOD_N   default number of requesting voice channels
//   state_e scheduler FSM states: IDLE -> WAIT -> DONE -> IDLE
// ---------------------------------------------------------------------------
package mod_pkg;

  localparam int MOD_W = 8;
  localparam int MOD_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_mult_scheduler_if.sv
// ---------------------------------------------------------------------------
// mod_mult_scheduler_if
// Bundles the channel request bus, the shared-multiplier connection and the
// result bus of mod_mult_scheduler.
//   req       N      per-channel request, held until granted
//   opa_flat  N*W    channel i operand A at [i*W +: W]
//   opb_flat  N*W    channel i operand B at [i*W +: W]
//   gnt       N      one-hot, one-cycle grant pulse
//   mult_a/b  W      operands driven to the shared multiplier
//   mult_p    2*W    product returned by the shared multiplier
//   res_valid 1      one-cycle pulse, res_data/res_ch valid
//   res_data  2*W    product for channel res_ch
//   res_ch    clog2N channel tag of res_data
//   busy      1      an operation is in flight
// Modports: slave = the scheduler, master = the surrounding system.
// ---------------------------------------------------------------------------
interface mod_mult_scheduler_if
  import mod_pkg::*;
#(
  parameter int N = MOD_N,
  parameter int W = MOD_W
);

  logic [N-1:0]         req;
  logic [N*W-1:0]       opa_flat;
  logic [N*W-1:0]       opb_flat;
  logic [N-1:0]         gnt;
  logic [W-1:0]         mult_a;
  logic [W-1:0]         mult_b;
  logic [2*W-1:0]       mult_p;
  logic                 res_valid;
  logic [2*W-1:0]       res_data;
  logic [$clog2(N)-1:0] res_ch;
  logic                 busy;

  modport slave (
    input  req, opa_flat, opb_flat, mult_p,
    output gnt, mult_a, mult_b, res_valid, res_data, res_ch, busy
  );

  modport master (
    output req, opa_flat, opb_flat, mult_p,
    input  gnt, mult_a, mult_b, res_valid, res_data, res_ch, busy
  );

endinterface

// File: rtl/mod_mult_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Picks one requesting channel per call and returns it both one-hot and
// encoded. Purely combinational; the caller owns the priority pointer.
//   req_i  N        request vector
//   ptr_i  clog2N   first channel to consider (round-robin build only)
//   gnt_o  N        one-hot winner, all zero when nobody requests
//   idx_o  clog2N   encoded winner, zero when nobody requests
// Configuration macro MOD_SCHED_FIXED_PRIO_EN: when defined the pointer input
// disappears and the lowest-index requester always wins.
// ---------------------------------------------------------------------------
module rr_arbiter
  import mod_pkg::*;
#(
  parameter int N = MOD_N
) (
  input  logic [N-1:0]         req_i,
`ifndef MOD_SCHED_FIXED_PRIO_EN
  input  logic [$clog2(N)-1:0] ptr_i,
`endif
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

`ifdef MOD_SCHED_FIXED_PRIO_EN
  // Scanning from the top down lets the lowest requesting index overwrite
  // any higher one, so channel 0 always has the highest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end
`else
  // Walk the channels starting at the pointer, wrapping past N-1 back to 0;
  // the first requester met wins. N need not be a power of two, so the wrap
  // is an explicit subtract rather than relying on bit truncation.
  always_comb begin
    logic found;
    int   cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/mod_mult_scheduler.sv
// ---------------------------------------------------------------------------
// mod_mult_scheduler
// Shares one pipelined multiplier between N voice channels. A granted
// channel's operands are registered onto the multiplier inputs, the block
// waits LAT cycles for the product, then returns it tagged with the channel.
// One operation is in flight at a time: gnt cycle to res_valid is LAT+2.
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous reset, active low
//   bus    slave modport of mod_mult_scheduler_if (req/operands in,
//          gnt, multiplier operands, product in, tagged result, busy)
// Parameters: N channels (2..8), W operand width, LAT multiplier latency (>=1).
// Configuration macro MOD_SCHED_FIXED_PRIO_EN: when defined the round-robin
// pointer is removed and channel 0 has fixed highest priority.
// ---------------------------------------------------------------------------
module mod_mult_scheduler
  import mod_pkg::*;
#(
  parameter int N   = MOD_N,
  parameter int W   = MOD_W,
  parameter int LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_mult_scheduler_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(LAT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  waitCnt_q, waitCnt_d;
  logic [IW-1:0]  tag_q, tag_d;
  logic [W-1:0]   multA_q, multA_d;
  logic [W-1:0]   multB_q, multB_d;
  logic           resValid_q, resValid_d;
  logic [2*W-1:0] resData_q, resData_d;
  logic [IW-1:0]  resCh_q, resCh_d;
`ifndef MOD_SCHED_FIXED_PRIO_EN
  logic [IW-1:0]  ptr_q, ptr_d;
`endif

  logic [N-1:0]   arbGnt;
  logic [IW-1:0]  arbIdx;
  logic           grantNow;

  rr_arbiter #(.N(N)) uArb (
    .req_i (bus.req),
`ifndef MOD_SCHED_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (arbGnt),
    .idx_o (arbIdx)
  );

  // A grant only happens from IDLE. During a reset cycle the operands would
  // not be captured, so no grant is advertised either.
  assign grantNow = rst_n && (state_q == IDLE) && (|bus.req);

  assign bus.gnt       = grantNow ? arbGnt : '0;
  assign bus.mult_a    = multA_q;
  assign bus.mult_b    = multB_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.res_ch    = resCh_q;
  assign bus.busy      = (state_q != IDLE);

  // Next-state logic. Everything holds by default; res_valid defaults low so
  // it can only ever be a single-cycle pulse following DONE. The pointer is
  // advanced past the served channel in DONE, making it lowest priority for
  // the next round.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    tag_d      = tag_q;
    multA_d    = multA_q;
    multB_d    = multB_q;
    resValid_d = 1'b0;
    resData_d  = resData_q;
    resCh_d    = resCh_q;
`ifndef MOD_SCHED_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grantNow) begin
          multA_d   = bus.opa_flat[int'(arbIdx) * W +: W];
          multB_d   = bus.opb_flat[int'(arbIdx) * W +: W];
          tag_d     = arbIdx;
          waitCnt_d = CW'(LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        waitCnt_d = waitCnt_q - CW'(1);
        if (waitCnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        resData_d  = bus.mult_p;
        resCh_d    = tag_q;
        resValid_d = 1'b1;
`ifndef MOD_SCHED_FIXED_PRIO_EN
        ptr_d      = (tag_q == IW'(N - 1)) ? '0 : tag_q + IW'(1);
`endif
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset returns straight to IDLE, which also discards any
  // operation in flight so its result is never reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      tag_q      <= '0;
      multA_q    <= '0;
      multB_q    <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resCh_q    <= '0;
`ifndef MOD_SCHED_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      tag_q      <= tag_d;
      multA_q    <= multA_d;
      multB_q    <= multB_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resCh_q    <= resCh_d;
`ifndef MOD_SCHED_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mod_mult_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mod_mult_scheduler
// Self-checking bench for mod_mult_scheduler. A timing/arbitration model
// predicts every output each cycle; directed sequences pin it with literal
// expectations, then randomized requests, operands and resets follow.
// Honours MOD_SCHED_FIXED_PRIO_EN for the expected grant orders.
// ---------------------------------------------------------------------------
module tb_mod_mult_scheduler;
  import mod_pkg::*;

  localparam int N   = MOD_N;
  localparam int W   = MOD_W;
  localparam int LAT = 1;
  localparam int PW  = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  mod_mult_scheduler_if #(.N(N), .W(W)) bus ();

  mod_mult_scheduler #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared multiplier stand-in: product appears LAT cycles after operands.
  logic [PW-1:0] multPipe [LAT];
  always @(posedge clk) begin
    multPipe[0] <= PW'(bus.mult_a) * PW'(bus.mult_b);
    for (int i = 1; i < LAT; i++) multPipe[i] <= multPipe[i-1];
  end
  assign bus.mult_p = multPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A grant may happen once the previous one is LAT+2 cycles old; its
  // result is due exactly LAT+2 cycles after the grant.
  typedef struct {
    int            due;
    logic [PW-1:0] data;
    int            ch;
  } res_t;

  res_t         pendQ[$];
  int           mPtr      = 0;
  int           mFreeAt   = 0;
  int           mGrantCyc = -100;
  logic [W-1:0] mA = '0;
  logic [W-1:0] mB = '0;
  bit           modelOn = 1'b0;

  function automatic int pickWinner(input logic [N-1:0] r, input int p);
`ifdef MOD_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
    if (p < 0) return -1;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  task automatic modelReset();
    pendQ.delete();
    mPtr      = 0;
    mFreeAt   = 0;
    mGrantCyc = -100;
    mA        = '0;
    mB        = '0;
  endtask

  always @(negedge clk) begin : compareProc
    logic [N-1:0] expGnt;
    bit           expBusy;
    bit           expValid;
    int           win;
    if (!modelOn) begin
      if (!rst_n) begin
        modelOn = 1'b1;
        modelReset();
      end
    end else begin
      expGnt = '0;
      win    = -1;
      if (rst_n && cyc >= mFreeAt && bus.req != '0) begin
        win         = pickWinner(bus.req, mPtr);
        expGnt[win] = 1'b1;
      end
      expBusy  = (cyc > mGrantCyc) && (cyc < mFreeAt);
      expValid = (pendQ.size() > 0) && (pendQ[0].due == cyc);
      checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
      checkOutput("busy", 32'(bus.busy), 32'(expBusy));
      checkOutput("res_valid", 32'(bus.res_valid), 32'(expValid));
      checkOutput("mult_a", 32'(bus.mult_a), 32'(mA));
      checkOutput("mult_b", 32'(bus.mult_b), 32'(mB));
      if (expValid) begin
        checkOutput("res_data", 32'(bus.res_data), 32'(pendQ[0].data));
        checkOutput("res_ch", 32'(bus.res_ch), 32'(pendQ[0].ch));
        void'(pendQ.pop_front());
      end
      if (win >= 0) begin
        mA = bus.opa_flat[win*W +: W];
        mB = bus.opb_flat[win*W +: W];
        pendQ.push_back('{due: cyc + LAT + 2,
                          data: PW'(int'(mA) * int'(mB)), ch: win});
        mGrantCyc = cyc;
        mFreeAt   = cyc + LAT + 2;
        mPtr      = (win + 1) % N;
      end
      if (!rst_n) modelReset();
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic [N-1:0] r);
    @(posedge clk);
    #1;
    bus.req = r;
  endtask

  task automatic setOperands(input int ch, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    bus.opa_flat[ch*W +: W] = a;
    bus.opb_flat[ch*W +: W] = b;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitGrant(input int maxCyc, output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        g = bus.gnt;
        return;
      end
    end
    checks++;
    failures++;
    $display("[TB] FAIL grant_timeout: no gnt within %0d cycles, required one", maxCyc);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : mainSeq
    logic [N-1:0] g;
    logic [N-1:0] order[5];
    logic [N-1:0] r;
    int           ch3Cnt;
    int           validCnt;

    bus.req      = '0;
    bus.opa_flat = '0;
    bus.opb_flat = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    repeat (10) @(negedge clk);
    checkOutput("idle_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("idle_busy", 32'(bus.busy), 32'h0);
    checkOutput("idle_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("idle_mult_a", 32'(bus.mult_a), 32'h0);
    checkOutput("idle_mult_b", 32'(bus.mult_b), 32'h0);

    // Single op: 0xFF * 0x02 on channel 0.
    setOperands(0, 8'hFF, 8'h02);
    applyStimulus(N'(1));
    @(negedge clk);
    checkOutput("single_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus('0);
    @(negedge clk);
    checkOutput("single_busy", 32'(bus.busy), 32'h1);
    checkOutput("single_mult_a", 32'(bus.mult_a), 32'hFF);
    repeat (2) @(negedge clk);
    checkOutput("single_valid", 32'(bus.res_valid), 32'h1);
    checkOutput("single_data", 32'(bus.res_data), 32'h01FE);
    checkOutput("single_ch", 32'(bus.res_ch), 32'h0);

    // All channels requesting continuously.
`ifdef MOD_SCHED_FIXED_PRIO_EN
    order = '{N'(1), N'(1), N'(1), N'(1), N'(1)};
`else
    order = '{N'(1), N'(2), N'(4), N'(8), N'(1)};
`endif
    resetDut();
    for (int i = 0; i < N; i++) setOperands(i, W'(16 + i), W'(3 + i));
    applyStimulus('1);
    for (int n = 0; n < 5; n++) begin
      waitGrant(LAT + 3, g);
      checkOutput($sformatf("all_req_order%0d", n), 32'(g), 32'(order[n]));
    end
    applyStimulus('0);
    repeat (LAT + 4) @(negedge clk);

    // ch2 served, then ch0 and ch2 compete: pointer wraps from 3 to 0.
    resetDut();
    applyStimulus(N'(4));
    waitGrant(4, g);
    checkOutput("wrap_first", 32'(g), 32'h4);
    applyStimulus(N'(5));
    waitGrant(LAT + 4, g);
    checkOutput("wrap_second", 32'(g), 32'h1);
    waitGrant(LAT + 4, g);
`ifdef MOD_SCHED_FIXED_PRIO_EN
    checkOutput("wrap_third", 32'(g), 32'h1);
`else
    checkOutput("wrap_third", 32'(g), 32'h4);
`endif
    applyStimulus('0);
    repeat (LAT + 4) @(negedge clk);

    // Reset while ch3 is in flight: result discarded, pointer back at 0.
    resetDut();
    applyStimulus(N'(4));
    waitGrant(4, g);
    applyStimulus('0);
    repeat (LAT + 3) @(negedge clk);
    applyStimulus(N'(8));
    waitGrant(4, g);
    checkOutput("abort_gnt", 32'(g), 32'h8);
    resetDut();
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(bus.res_valid), 32'h0);
    end
    setOperands(1, 8'h12, 8'h34);
    applyStimulus(N'(10));
    waitGrant(4, g);
    checkOutput("after_abort_gnt", 32'(g), 32'h2);
    applyStimulus('0);
    repeat (LAT + 3) @(negedge clk);

    // ch3 pulses only while ch1 is in flight: never served.
    resetDut();
    applyStimulus(N'(2));
    waitGrant(4, g);
    checkOutput("pulse_gnt", 32'(g), 32'h2);
    applyStimulus(N'(8));
    applyStimulus('0);
    ch3Cnt   = 0;
    validCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt[3]) ch3Cnt++;
      if (bus.res_valid) validCnt++;
    end
    checkOutput("pulse_ch3_grants", 32'(ch3Cnt), 32'h0);
    checkOutput("pulse_results", 32'(validCnt), 32'h1);

    // Randomized traffic with occasional resets.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < 25) r[i] = ~r[i];
        bus.opa_flat[i*W +: W] = W'($urandom);
        bus.opb_flat[i*W +: W] = W'($urandom);
      end
      bus.req = r;
      rst_n   = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.req = '0;
    repeat (LAT + 6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
